// File: rtl/general_group_decoder_pkg.sv
// Shared instruction-format constants for all group decoders; GEN_ILLEGAL_TRAP_EN
// (see top) only changes decoder ports, not these encodings.
package general_group_decoder_pkg;

  localparam int INSTR_W  = 16;
  localparam int GROUP_HI = 15;
  localparam int GROUP_LO = 14;
  localparam int SUB_HI   = 13;
  localparam int SUB_LO   = 11;
  localparam int OP_HI    = 10;
  localparam int OP_LO    = 8;

  typedef enum logic [1:0] {
    GROUP_SYSTEM = 2'b00,
    GROUP_ALU    = 2'b01,
    GROUP_MEM    = 2'b10,
    GROUP_BRANCH = 2'b11
  } group_e;

  typedef enum logic [2:0] {
    GEN_OP_NOP  = 3'b000,
    GEN_OP_EI   = 3'b001,
    GEN_OP_DI   = 3'b010,
    GEN_OP_RETI = 3'b011,
    GEN_OP_HALT = 3'b100
  } gen_op_e;

  // Shared with the ALU decoder; listed here so every decoder sees one encoding.
  localparam logic [2:0] ALU_OP_ADD = 3'b000;
  localparam logic [2:0] ALU_OP_SUB = 3'b001;
  localparam logic [2:0] ALU_OP_MOV = 3'b111;
  localparam logic       MODE_REG   = 1'b0;
  localparam logic       MODE_IMM   = 1'b1;

  typedef struct packed {
    logic is_ei;
    logic is_di;
    logic is_reti;
    logic is_halt;
    logic is_illegal;
  } gen_dec_t;

endpackage

// File: rtl/general_group_decoder_if.sv
// Phase/instruction bundle from the sequencer and the decoder's control outputs.
// ILLEGALX exists only when GEN_ILLEGAL_TRAP_EN is defined.
interface general_group_decoder_if;
  logic [15:0] INSTRUCTION;
  logic        FETCH;
  logic        DECODE;
  logic        EXECUTE;
  logic        COMMIT;
  logic        EIX;
  logic        DIX;
  logic        RETIX;
  logic        PC_ENX;
`ifdef GEN_ILLEGAL_TRAP_EN
  logic        ILLEGALX;
`endif

  modport master (
    output INSTRUCTION, FETCH, DECODE, EXECUTE, COMMIT,
`ifdef GEN_ILLEGAL_TRAP_EN
    input  ILLEGALX,
`endif
    input  EIX, DIX, RETIX, PC_ENX
  );

  modport slave (
    input  INSTRUCTION, FETCH, DECODE, EXECUTE, COMMIT,
`ifdef GEN_ILLEGAL_TRAP_EN
    output ILLEGALX,
`endif
    output EIX, DIX, RETIX, PC_ENX
  );
endinterface

// File: rtl/general_group_decoder_gen_op_decode.sv
// Combinational SYSTEM-group op decode: instruction word -> one-hot op flags, zero latency.
module general_group_decoder_gen_op_decode
  import general_group_decoder_pkg::*;
(
  input  logic [INSTR_W-1:0] instruction,
  output gen_dec_t           dec
);

  logic       sys_hit;
  logic [2:0] op;
  logic [2:0] sub;
  logic       unused_low_bits;

  assign sys_hit         = (instruction[GROUP_HI:GROUP_LO] == GROUP_SYSTEM);
  assign op              = instruction[OP_HI:OP_LO];
  assign sub             = instruction[SUB_HI:SUB_LO];
  assign unused_low_bits = ^instruction[OP_LO-1:0];

  // Strobe ops look only at the op field; a non-zero sub field is flagged
  // separately as illegal rather than suppressing the strobe.
  assign dec.is_ei      = sys_hit && (op == GEN_OP_EI);
  assign dec.is_di      = sys_hit && (op == GEN_OP_DI);
  assign dec.is_reti    = sys_hit && (op == GEN_OP_RETI);
  assign dec.is_halt    = sys_hit && (op == GEN_OP_HALT);
  assign dec.is_illegal = sys_hit && ((op > GEN_OP_HALT) || (sub != 3'b000));

endmodule

// File: rtl/general_group_decoder.sv
// SYSTEM-group decoder: strobes captured on DECODE edge, cleared on COMMIT edge; HALT drops PC_ENX
// on its COMMIT edge until RESET. Define GEN_ILLEGAL_TRAP_EN to add the ILLEGALX output.
module general_group_decoder
  import general_group_decoder_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RESET,
  general_group_decoder_if.slave bus
);

  gen_dec_t dec;
  logic     ei_q;
  logic     di_q;
  logic     reti_q;
  logic     halt_pend;
  logic     pc_en_q;
  logic     illegal_q;
  logic     halt_at_commit;
  logic     unused_phases;

  general_group_decoder_gen_op_decode u_gen_op_decode (
    .instruction (bus.INSTRUCTION),
    .dec         (dec)
  );

  // With DECODE and COMMIT both hot, COMMIT acts on what DECODE just latched.
  assign halt_at_commit = bus.DECODE ? dec.is_halt : halt_pend;
  assign unused_phases  = bus.FETCH ^ bus.EXECUTE;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ei_q      <= 1'b0;
      di_q      <= 1'b0;
      reti_q    <= 1'b0;
      illegal_q <= 1'b0;
      halt_pend <= 1'b0;
      pc_en_q   <= 1'b1;
    end else begin
      if (bus.DECODE) begin
        ei_q      <= dec.is_ei;
        di_q      <= dec.is_di;
        reti_q    <= dec.is_reti;
        illegal_q <= dec.is_illegal;
        halt_pend <= dec.is_halt;
      end
      if (bus.COMMIT) begin
        ei_q      <= 1'b0;
        di_q      <= 1'b0;
        reti_q    <= 1'b0;
        illegal_q <= 1'b0;
        halt_pend <= 1'b0;
        if (halt_at_commit) begin
          pc_en_q <= 1'b0;
        end
      end
    end
  end

  assign bus.EIX    = ei_q;
  assign bus.DIX    = di_q;
  assign bus.RETIX  = reti_q;
  assign bus.PC_ENX = pc_en_q;

`ifdef GEN_ILLEGAL_TRAP_EN
  assign bus.ILLEGALX = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_general_group_decoder.sv
// Randomized phase-sequenced bench for general_group_decoder against a per-instruction reference model.
module tb_general_group_decoder;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  general_group_decoder_if bus ();

  general_group_decoder dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit halted = 1'b0;

  task automatic set_phase(input logic [3:0] p);
    {bus.FETCH, bus.DECODE, bus.EXECUTE, bus.COMMIT} = p;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: strobes live after DECODE and EXECUTE only; PC_ENX low once a HALT has committed.
  task automatic run_instr(input logic [15:0] ins);
    bit       sys;
    int       op;
    bit       ill;
    bit       live;
    bit [2:0] exp_s;
    sys = (ins[15:14] == 2'b00);
    op  = int'(ins[10:8]);
    ill = sys && (op > 4 || ins[13:11] != 3'b000);
    for (int ph = 0; ph < 4; ph++) begin
      bus.INSTRUCTION = ins;
      set_phase(4'b1000 >> ph);
      tick();
      live = (ph == 1 || ph == 2);
      if (ph == 3 && sys && op == 4) halted = 1'b1;
      exp_s = {live && sys && op == 1, live && sys && op == 2, live && sys && op == 3};
      checks++;
      if ({bus.EIX, bus.DIX, bus.RETIX} !== exp_s) begin
        errors++;
        $display("FAIL strobes instr=%h phase=%0d: got EI/DI/RETI=%b expected %b",
                 ins, ph, {bus.EIX, bus.DIX, bus.RETIX}, exp_s);
      end
      checks++;
      if (bus.PC_ENX !== !halted) begin
        errors++;
        $display("FAIL pc_en instr=%h phase=%0d: got %b expected %b", ins, ph, bus.PC_ENX, !halted);
      end
`ifdef GEN_ILLEGAL_TRAP_EN
      checks++;
      if (bus.ILLEGALX !== (live && ill)) begin
        errors++;
        $display("FAIL illegal instr=%h phase=%0d: got %b expected %b", ins, ph, bus.ILLEGALX, live && ill);
      end
`endif
    end
    set_phase(4'b0000);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.INSTRUCTION = 16'($urandom);
      set_phase(4'($urandom));
      tick();
    end
    RESET  = 1'b0;
    halted = 1'b0;
    set_phase(4'b0000);
    checks++;
    if ({bus.EIX, bus.DIX, bus.RETIX, bus.PC_ENX} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_state: got EI/DI/RETI/PC=%b expected 0001", {bus.EIX, bus.DIX, bus.RETIX, bus.PC_ENX});
    end
`ifdef GEN_ILLEGAL_TRAP_EN
    checks++;
    if (bus.ILLEGALX !== 1'b0) begin
      errors++;
      $display("FAIL reset_illegal: got %b expected 0", bus.ILLEGALX);
    end
`endif
  endtask

  task automatic test_non_system();
    run_instr(16'h40AF);
    for (int i = 0; i < 10; i++) run_instr({2'($urandom_range(1, 3)), 14'($urandom)});
  endtask

  task automatic test_nop();
    run_instr(16'h0000);
    run_instr({8'h00, 8'($urandom)});
  endtask

  task automatic test_strobes();
    run_instr(16'h0100);
    run_instr(16'h0200);
    run_instr(16'h0300);
    for (int i = 0; i < 12; i++) run_instr({5'b00000, 3'($urandom_range(0, 3)), 8'($urandom)});
  endtask

  task automatic test_undefined();
    run_instr(16'h0700);
    run_instr({5'b00000, 3'($urandom_range(5, 7)), 8'($urandom)});
    run_instr({2'b00, 3'($urandom_range(1, 7)), 3'b001, 8'($urandom)});
  endtask

  task automatic test_back_to_back();
    logic [15:0] ins;
    for (int i = 0; i < 30; i++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 1) == 0) ins[15:14] = 2'b00;
      if ($urandom_range(0, 3) != 0) ins[13:11] = 3'b000;
      if (ins[15:14] == 2'b00 && ins[10:8] == 3'b100) ins[10:8] = 3'b000;
      run_instr(ins);
    end
  endtask

  task automatic test_hold();
    bus.INSTRUCTION = {8'h02, 8'($urandom)};
    set_phase(4'b1000); tick();
    set_phase(4'b0100); tick();
    for (int i = 0; i < 3; i++) begin
      bus.INSTRUCTION = 16'($urandom);
      set_phase(4'b0000);
      tick();
      checks++;
      if ({bus.EIX, bus.DIX, bus.RETIX} !== 3'b010) begin
        errors++;
        $display("FAIL hold_idle cycle=%0d: got %b expected 010", i, {bus.EIX, bus.DIX, bus.RETIX});
      end
    end
    set_phase(4'b0001); tick();
    set_phase(4'b0000);
    checks++;
    if ({bus.EIX, bus.DIX, bus.RETIX} !== 3'b000) begin
      errors++;
      $display("FAIL hold_commit: got %b expected 000", {bus.EIX, bus.DIX, bus.RETIX});
    end
  endtask

  task automatic test_multi_hot();
    bus.INSTRUCTION = 16'h0100;
    set_phase(4'b0101); tick();
    checks++;
    if ({bus.EIX, bus.DIX, bus.RETIX} !== 3'b000) begin
      errors++;
      $display("FAIL decode_commit: got %b expected 000", {bus.EIX, bus.DIX, bus.RETIX});
    end
    bus.INSTRUCTION = 16'h0300;
    set_phase(4'b0110); tick();
    checks++;
    if ({bus.EIX, bus.DIX, bus.RETIX} !== 3'b001) begin
      errors++;
      $display("FAIL decode_execute: got %b expected 001", {bus.EIX, bus.DIX, bus.RETIX});
    end
    set_phase(4'b0001); tick();
    set_phase(4'b0000);
    checks++;
    if ({bus.EIX, bus.DIX, bus.RETIX, bus.PC_ENX} !== 4'b0001) begin
      errors++;
      $display("FAIL multi_hot_clear: got %b expected 0001", {bus.EIX, bus.DIX, bus.RETIX, bus.PC_ENX});
    end
  endtask

  task automatic test_reset_priority();
    bus.INSTRUCTION = 16'h0100;
    set_phase(4'b0100); tick();
    RESET = 1'b1;
    bus.INSTRUCTION = 16'h0200;
    set_phase(4'b0100); tick();
    RESET = 1'b0;
    set_phase(4'b0000);
    checks++;
    if ({bus.EIX, bus.DIX, bus.RETIX, bus.PC_ENX} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_vs_decode: got %b expected 0001", {bus.EIX, bus.DIX, bus.RETIX, bus.PC_ENX});
    end
  endtask

  task automatic test_halt();
    run_instr({8'h04, 8'($urandom)});
    run_instr(16'h0100);
    for (int i = 0; i < 4; i++) run_instr({2'($urandom_range(0, 3)), 3'b000, 3'($urandom_range(0, 3)), 8'($urandom)});
    RESET = 1'b1;
    set_phase(4'b0001); tick();
    RESET  = 1'b0;
    halted = 1'b0;
    set_phase(4'b0000);
    checks++;
    if (bus.PC_ENX !== 1'b1) begin
      errors++;
      $display("FAIL halt_reset_restore: got %b expected 1", bus.PC_ENX);
    end
    run_instr(16'h0000);
    run_instr(16'h0200);
  endtask

  initial begin
    RESET = 1'b1;
    bus.INSTRUCTION = 16'h0000;
    set_phase(4'b0000);
    test_reset();
    test_non_system();
    test_nop();
    test_strobes();
    test_undefined();
    test_back_to_back();
    test_hold();
    test_multi_hot();
    test_reset_priority();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
